// File: rtl/hash_bits_off_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// hash_bits_off_arbiter_pkg
//   Shared definitions for the hash_bits_off arbiter:
//   - state_e  : arbiter FSM state encoding (IDLE/START/WAIT/COMMIT)
//   - clog2_f  : ceil(log2(v)) helper, never smaller than 1, usable in
//                parameter expressions
// ----------------------------------------------------------------------------
package hash_bits_off_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hash_bits_off_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// hbo_rr_picker
//   Combinational round-robin selector: returns the first set request at or
//   after the pointer, wrapping around N_REQ.
// Ports
//   req    in   N_REQ   request vector
//   ptr    in   SRC_W   round-robin start position
//   idx    out  SRC_W   selected request index (0 when none)
//   valid  out  1       at least one request is set
// ----------------------------------------------------------------------------
module hbo_rr_picker
    import hash_bits_off_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SRC_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] idx,
    output logic             valid
);

    int p;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        p     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            p = int'(ptr) + i;
            if (p >= N_REQ) begin
                p = p - N_REQ;
            end
            if (!valid && req[p[SRC_W-1:0]]) begin
                valid = 1'b1;
                idx   = p[SRC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hash_bits_off_arbiter.sv
// ----------------------------------------------------------------------------
// hash_bits_off_arbiter
//   Shares one hash_bits_off unit among N_REQ hash cores. A round-robin picker
//   grants one core, its hash is muxed onto the unit, the unit is started and
//   awaited, the core is acked, and the lowest bits-off result seen so far is
//   kept together with the index of the core that produced it.
//
// Configuration macro: HBO_ARB_TIMEOUT_EN
//   defined   : WAIT watchdog; after TIMEOUT cycles without unit_done_i the job
//               is aborted (timeout_o pulse, core acked, best untouched).
//   undefined : WAIT lasts until unit_done_i, timeout_o stays 0.
//
// Ports
//   clk_i            in   clock
//   rst_n_i          in   asynchronous reset, active-low
//   req_i            in   per-core request, held until ack
//   hash_i           in   packed hashes, core k at [k*HASH_W +: HASH_W]
//   ack_o            out  1-cycle per-core ack
//   unit_start_o     out  1-cycle start pulse to the shared unit
//   unit_hash_o      out  hash of the granted core
//   unit_done_i      in   shared unit finished
//   unit_bits_off_i  in   result, valid with unit_done_i
//   best_valid_o     out  a result has been committed
//   best_bits_off_o  out  lowest committed count
//   best_src_o       out  core that produced best_bits_off_o
//   new_best_o       out  1-cycle pulse on best update
//   timeout_o        out  1-cycle pulse on watchdog abort
// ----------------------------------------------------------------------------
module hash_bits_off_arbiter
    import hash_bits_off_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int HASH_W  = 1024,
    parameter int CNT_W   = 11,
    parameter int SRC_W   = 2,
    parameter int TIMEOUT = 2048
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*HASH_W-1:0] hash_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    unit_start_o,
    output logic [HASH_W-1:0]       unit_hash_o,
    input  logic                    unit_done_i,
    input  logic [CNT_W-1:0]        unit_bits_off_i,
    output logic                    best_valid_o,
    output logic [CNT_W-1:0]        best_bits_off_o,
    output logic [SRC_W-1:0]        best_src_o,
    output logic                    new_best_o,
    output logic                    timeout_o
);

    localparam int TO_W = clog2_f(TIMEOUT);

`ifdef HBO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_e           state;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant;
    logic [TO_W-1:0]  wait_cnt;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_valid;
    logic             timeout_hit;
    logic [SRC_W-1:0] rr_next;

    hbo_rr_picker #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_picker (
        .req   (req_i),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Watchdog fires on the cycle the counter shows TIMEOUT-1, so the abort
    // becomes visible TIMEOUT cycles after WAIT entry. Done has priority.
    assign timeout_hit = TO_EN && (wait_cnt == TO_W'(TIMEOUT - 1));

    assign rr_next = (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            wait_cnt        <= '0;
            ack_o           <= '0;
            unit_start_o    <= 1'b0;
            unit_hash_o     <= '0;
            best_valid_o    <= 1'b0;
            best_bits_off_o <= '1;
            best_src_o      <= '0;
            new_best_o      <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            // pulse outputs default low; set for exactly one cycle below
            ack_o        <= '0;
            unit_start_o <= 1'b0;
            new_best_o   <= 1'b0;
            timeout_o    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant        <= pick_idx;
                        unit_hash_o  <= hash_i[int'(pick_idx)*HASH_W +: HASH_W];
                        unit_start_o <= 1'b1;
                        state        <= ST_START;
                    end
                end

                ST_START: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end

                // The result is judged here so that ack, new_best and the
                // updated best all appear together in the COMMIT cycle.
                ST_WAIT: begin
                    if (unit_done_i) begin
                        ack_o[grant] <= 1'b1;
                        state        <= ST_COMMIT;
                        if (!best_valid_o || (unit_bits_off_i < best_bits_off_o)) begin
                            best_valid_o    <= 1'b1;
                            best_bits_off_o <= unit_bits_off_i;
                            best_src_o      <= grant;
                            new_best_o      <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        ack_o[grant] <= 1'b1;
                        timeout_o    <= 1'b1;
                        state        <= ST_COMMIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_COMMIT: begin
                    rr_ptr <= rr_next;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_bits_off_arbiter.sv
module tb_hash_bits_off_arbiter;

    localparam int N_REQ  = 4;
    localparam int HASH_W = 1024;
    localparam int CNT_W  = 11;
    localparam int SRC_W  = 2;
`ifdef HBO_ARB_TIMEOUT_EN
    localparam int TB_TO  = 16;
    localparam int D1     = 10;
`else
    localparam int TB_TO  = 2048;
    localparam int D1     = 1024;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_n_i;
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*HASH_W-1:0] hash_i;
    logic [N_REQ-1:0]        ack_o;
    logic                    unit_start_o;
    logic [HASH_W-1:0]       unit_hash_o;
    logic                    unit_done_i;
    logic [CNT_W-1:0]        unit_bits_off_i;
    logic                    best_valid_o;
    logic [CNT_W-1:0]        best_bits_off_o;
    logic [SRC_W-1:0]        best_src_o;
    logic                    new_best_o;
    logic                    timeout_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int to_seen = 0;
    int last_ack = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) if (timeout_o) to_seen <= to_seen + 1;

    hash_bits_off_arbiter #(
        .N_REQ(N_REQ), .HASH_W(HASH_W), .CNT_W(CNT_W), .SRC_W(SRC_W), .TIMEOUT(TB_TO)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .hash_i(hash_i),
        .ack_o(ack_o), .unit_start_o(unit_start_o), .unit_hash_o(unit_hash_o),
        .unit_done_i(unit_done_i), .unit_bits_off_i(unit_bits_off_i),
        .best_valid_o(best_valid_o), .best_bits_off_o(best_bits_off_o),
        .best_src_o(best_src_o), .new_best_o(new_best_o), .timeout_o(timeout_o)
    );

    function automatic logic [HASH_W-1:0] core_hash(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(k);
        return {32{w}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the start pulse, sampling on falling edges.
    task automatic wait_start(input int src);
        int n;
        n = 0;
        while (!unit_start_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        chk("start_seen", 64'(unit_start_o), 64'd1);
        chk("grant_hash", unit_hash_o[63:0], core_hash(src)[63:0]);
    endtask

    // One job: start observed, done after d cycles, checks at COMMIT and after.
    task automatic do_job(input int d, input logic [CNT_W-1:0] bits, input int src,
                          input bit exp_new, input bit drop);
        wait_start(src);
        repeat (d) @(negedge clk_i);
        unit_done_i     = 1'b1;
        unit_bits_off_i = bits;
        @(negedge clk_i);
        unit_done_i = 1'b0;
        chk("ack", 64'(ack_o), 64'(4'b0001 << src));
        chk("new_best", 64'(new_best_o), 64'(exp_new));
        last_ack = cyc;
        if (drop) req_i[src] = 1'b0;
        @(negedge clk_i);
        chk("ack_once", 64'(ack_o), 64'd0);
        chk("new_best_once", 64'(new_best_o), 64'd0);
    endtask

    logic [CNT_W-1:0] t2_bits [5] = '{11'd100, 11'd90, 11'd95, 11'd90, 11'd50};
    bit               t2_new  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int               t2_bsrc [5] = '{0, 1, 1, 1, 0};

    initial begin
        int prev;
        int cs;
        int n;
        rst_n_i = 1'b0;
        req_i = '0;
        unit_done_i = 1'b0;
        unit_bits_off_i = '0;
        for (int k = 0; k < N_REQ; k++) hash_i[k*HASH_W +: HASH_W] = core_hash(k);

        // reset state
        repeat (3) @(negedge clk_i);
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_start", 64'(unit_start_o), 64'd0);
        chk("rst_valid", 64'(best_valid_o), 64'd0);
        chk("rst_best", 64'(best_bits_off_o), 64'h7FF);
        chk("rst_src", 64'(best_src_o), 64'd0);
        chk("rst_hash", unit_hash_o[63:0], 64'd0);
        chk("rst_newbest", 64'(new_best_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        rst_n_i = 1'b1;

        // single request from core 2
        req_i = 4'b0100;
        do_job(D1, 11'd400, 2, 1'b1, 1'b1);
        chk("t1_best", 64'(best_bits_off_o), 64'd400);
        chk("t1_src", 64'(best_src_o), 64'd2);
        chk("t1_valid", 64'(best_valid_o), 64'd1);

        // tie keeps earlier result, strictly lower replaces it
        req_i = 4'b1000;
        do_job(3, 11'd400, 3, 1'b0, 1'b1);
        chk("t3_tie_best", 64'(best_bits_off_o), 64'd400);
        chk("t3_tie_src", 64'(best_src_o), 64'd2);
        req_i = 4'b0010;
        do_job(3, 11'd399, 1, 1'b1, 1'b1);
        chk("t3_best", 64'(best_bits_off_o), 64'd399);
        chk("t3_src", 64'(best_src_o), 64'd1);

        // done pulses while idle are ignored
        unit_done_i = 1'b1;
        unit_bits_off_i = 11'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t5_ack", 64'(ack_o), 64'd0);
            chk("t5_start", 64'(unit_start_o), 64'd0);
            chk("t5_newbest", 64'(new_best_o), 64'd0);
        end
        unit_done_i = 1'b0;
        chk("t5_best", 64'(best_bits_off_o), 64'd399);
        chk("t5_src", 64'(best_src_o), 64'd1);

        // reset in the middle of WAIT discards the job
        req_i = 4'b0010;
        wait_start(1);
        repeat (5) @(negedge clk_i);
        rst_n_i = 1'b0;
        req_i = '0;
        #1;
        chk("t4_ack", 64'(ack_o), 64'd0);
        chk("t4_valid", 64'(best_valid_o), 64'd0);
        chk("t4_best", 64'(best_bits_off_o), 64'h7FF);
        chk("t4_src", 64'(best_src_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("t4_noack", 64'(ack_o), 64'd0);

        // all requests held: grants rotate 0,1,2,3,0 starting from core 0
        req_i = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            do_job(4, t2_bits[i], i % N_REQ, t2_new[i], 1'b0);
            if (i > 0) chk("t2_spacing", 64'(last_ack - prev), 64'd7);
            prev = last_ack;
            chk("t2_best_src", 64'(best_src_o), 64'(t2_bsrc[i]));
        end
        req_i = '0;
        chk("t2_best", 64'(best_bits_off_o), 64'd50);

`ifdef HBO_ARB_TIMEOUT_EN
        // watchdog: done never arrives
        req_i = 4'b0100;
        wait_start(2);
        cs = cyc;
        n = 0;
        while (!timeout_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        chk("t6_timeout_seen", 64'(timeout_o), 64'd1);
        chk("t6_latency", 64'(cyc - cs), 64'(TB_TO + 1));
        chk("t6_ack", 64'(ack_o), 64'b0100);
        chk("t6_newbest", 64'(new_best_o), 64'd0);
        req_i = '0;
        @(negedge clk_i);
        chk("t6_timeout_once", 64'(timeout_o), 64'd0);
        chk("t6_best", 64'(best_bits_off_o), 64'd50);
        chk("t6_src", 64'(best_src_o), 64'd0);
`else
        cs = 0;
        n = 0;
        repeat (4) @(negedge clk_i);
        chk("timeout_tied", 64'(to_seen + cs + n), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
